// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared phase encodings, light codes and direction constants for the
// intersection phase scheduler.
package tlc_pkg;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // {red,yellow,green}
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Saturating up-counter cleared on each phase entry, with a done flag
// asserted once the count reaches limit-1.
module phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // >= rather than == so a count held at saturation (emergency hold) still reads done
  assign o_done = (r_cnt >= (i_limit - W'(1)));
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach traffic phase sequencer with pedestrian walk, sticky demand
// flags and emergency preempt. Moore outputs decoded from the phase register.
module intersection_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned WALK_CYCLES   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam int unsigned CW =
    $clog2(max4(MIN_GREEN, YELLOW_CYCLES, ALLRED_CYCLES, WALK_CYCLES) + 1);

  phase_e          r_phase;
  phase_e          w_next;
  dir_e            r_next_dir;
  logic            r_ns_pend;
  logic            r_ew_pend;
  logic            r_ped_pend;
  logic [CW-1:0]   w_cnt;
  logic [CW-1:0]   w_limit;
  logic            w_done;
  logic            w_enter;
  logic            w_min_green;
  phase_e          w_dir_green;

  phase_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_enter),
    .i_limit (w_limit),
    .o_cnt   (w_cnt),
    .o_done  (w_done)
  );

  assign w_min_green = (w_cnt >= CW'(MIN_GREEN - 1));
  assign w_dir_green = (r_next_dir == DIR_NS) ? NS_GREEN : EW_GREEN;
  assign w_enter     = (w_next != r_phase);

  always_comb begin
    w_limit = CW'(ALLRED_CYCLES);
    case (r_phase)
      NS_YELLOW, EW_YELLOW: w_limit = CW'(YELLOW_CYCLES);
      PED_WALK:             w_limit = CW'(WALK_CYCLES);
      default:              w_limit = CW'(ALLRED_CYCLES);
    endcase
  end

  always_comb begin
    w_next = r_phase;
    case (r_phase)
      ALL_RED: begin
        if (w_done && !emergency) w_next = r_ped_pend ? PED_WALK : w_dir_green;
      end
      NS_GREEN: begin
        if (emergency || (w_min_green && (r_ew_pend || r_ped_pend))) w_next = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (w_done) w_next = ALL_RED;
      end
      EW_GREEN: begin
        if (emergency || (w_min_green && (r_ns_pend || r_ped_pend))) w_next = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (w_done) w_next = ALL_RED;
      end
      PED_WALK: begin
        if (emergency)   w_next = ALL_RED;
        else if (w_done) w_next = w_dir_green;
      end
      default: w_next = ALL_RED;
    endcase
  end

  // Entry clears take priority over a request arriving on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= ALL_RED;
      r_next_dir <= DIR_NS;
      r_ns_pend  <= 1'b0;
      r_ew_pend  <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_phase    <= w_next;
      r_ns_pend  <= (w_enter && (w_next == NS_GREEN)) ? 1'b0 : (r_ns_pend | ns_req);
      r_ew_pend  <= (w_enter && (w_next == EW_GREEN)) ? 1'b0 : (r_ew_pend | ew_req);
      r_ped_pend <= (w_enter && (w_next == PED_WALK)) ? 1'b0 :
                    (r_ped_pend | ped_req | ((r_phase == PED_WALK) && emergency));
      if (w_enter && (w_next == NS_YELLOW)) r_next_dir <= DIR_EW;
      if (w_enter && (w_next == EW_YELLOW)) r_next_dir <= DIR_NS;
    end
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    ped_walk = 1'b0;
    case (r_phase)
      NS_GREEN:  ns_light = LIGHT_GRN;
      NS_YELLOW: ns_light = LIGHT_YEL;
      EW_GREEN:  ew_light = LIGHT_GRN;
      EW_YELLOW: ew_light = LIGHT_YEL;
      PED_WALK:  ped_walk = 1'b1;
      default:   ;
    endcase
  end

  assign phase = r_phase;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed-vector bench for intersection_phase_scheduler with default timing.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset, ns_req, ew_req, ped_req, emergency;
  logic [2:0] ns_light, ew_light, phase;
  logic       ped_walk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .MIN_GREEN     (4),
    .YELLOW_CYCLES (3),
    .ALLRED_CYCLES (2),
    .WALK_CYCLES   (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ns_req    (ns_req),
    .ew_req    (ew_req),
    .ped_req   (ped_req),
    .emergency (emergency),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ped_walk  (ped_walk),
    .phase     (phase)
  );

  typedef struct {
    int         n;
    logic       rst, nr, er, pr, em;
    logic [2:0] ph, ns, ew;
    logic       walk;
  } vec_t;

  vec_t tbl[19];

  task automatic cyc(input logic rst, input logic nr, input logic er,
                     input logic pr, input logic em);
    reset = rst; ns_req = nr; ew_req = er; ped_req = pr; emergency = em;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] eph, input logic [2:0] ens,
                     input logic [2:0] eew, input logic ewalk);
    n_vec++;
    if (phase !== eph || ns_light !== ens || ew_light !== eew || ped_walk !== ewalk) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d ns=%b ew=%b walk=%b, want phase=%0d ns=%b ew=%b walk=%b",
               name, phase, ns_light, ew_light, ped_walk, eph, ens, eew, ewalk);
    end
  endtask

  initial begin
    reset = 1'b1; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0; emergency = 1'b0;

    // reset, idle rest, then demand at minimum green and a pedestrian walk
    tbl[0]  = '{2,  1,0,0,0,0, 3'd0, R, R, 1'b0};
    tbl[1]  = '{1,  0,0,0,0,0, 3'd0, R, R, 1'b0};
    tbl[2]  = '{1,  0,0,0,0,0, 3'd1, G, R, 1'b0};
    tbl[3]  = '{50, 0,0,0,0,0, 3'd1, G, R, 1'b0};
    tbl[4]  = '{1,  1,0,0,0,0, 3'd0, R, R, 1'b0};
    tbl[5]  = '{1,  0,0,0,0,0, 3'd0, R, R, 1'b0};
    tbl[6]  = '{1,  0,0,0,0,0, 3'd1, G, R, 1'b0};
    tbl[7]  = '{1,  0,0,0,0,0, 3'd1, G, R, 1'b0};
    tbl[8]  = '{1,  0,0,1,0,0, 3'd1, G, R, 1'b0};
    tbl[9]  = '{1,  0,0,0,0,0, 3'd1, G, R, 1'b0};
    tbl[10] = '{3,  0,0,0,0,0, 3'd2, Y, R, 1'b0};
    tbl[11] = '{2,  0,0,0,0,0, 3'd0, R, R, 1'b0};
    tbl[12] = '{1,  0,0,0,0,0, 3'd3, R, G, 1'b0};
    tbl[13] = '{3,  0,0,0,0,0, 3'd3, R, G, 1'b0};
    tbl[14] = '{1,  0,0,0,1,0, 3'd3, R, G, 1'b0};
    tbl[15] = '{3,  0,0,0,0,0, 3'd4, R, Y, 1'b0};
    tbl[16] = '{2,  0,0,0,0,0, 3'd0, R, R, 1'b0};
    tbl[17] = '{5,  0,0,0,0,0, 3'd5, R, R, 1'b1};
    tbl[18] = '{10, 0,0,0,0,0, 3'd1, G, R, 1'b0};

    for (int i = 0; i < 19; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc(tbl[i].rst, tbl[i].nr, tbl[i].er, tbl[i].pr, tbl[i].em);
        chk($sformatf("tbl[%0d].%0d", i, k), tbl[i].ph, tbl[i].ns, tbl[i].ew, tbl[i].walk);
      end
    end

    // emergency from NS_GREEN cnt=0: full yellow, then hold in ALL_RED
    cyc(1,0,0,0,0); chk("emg_rst", 3'd0, R, R, 1'b0);
    cyc(0,0,0,0,0); chk("emg_ar", 3'd0, R, R, 1'b0);
    cyc(0,0,0,0,0); chk("emg_nsg", 3'd1, G, R, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(0,0,0,0,1);
      if (i < 3) chk($sformatf("emg_yel%0d", i), 3'd2, Y, R, 1'b0);
      else       chk($sformatf("emg_hold%0d", i), 3'd0, R, R, 1'b0);
    end
    cyc(0,0,0,0,0); chk("emg_ewg", 3'd3, R, G, 1'b0);

    // walk aborted at PED_WALK cnt=2 and re-served in full
    cyc(0,0,0,1,0); chk("ab_ewg1", 3'd3, R, G, 1'b0);
    for (int i = 0; i < 2; i++) begin cyc(0,0,0,0,0); chk("ab_ewg", 3'd3, R, G, 1'b0); end
    for (int i = 0; i < 3; i++) begin cyc(0,0,0,0,0); chk("ab_ewy", 3'd4, R, Y, 1'b0); end
    for (int i = 0; i < 2; i++) begin cyc(0,0,0,0,0); chk("ab_ar", 3'd0, R, R, 1'b0); end
    for (int i = 0; i < 3; i++) begin cyc(0,0,0,0,0); chk("ab_walk", 3'd5, R, R, 1'b1); end
    cyc(0,0,0,0,1); chk("ab_abort", 3'd0, R, R, 1'b0);
    cyc(0,0,0,0,0); chk("ab_ar2", 3'd0, R, R, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,0,0,0); chk($sformatf("ab_rewalk%0d", i), 3'd5, R, R, 1'b1);
    end
    cyc(0,0,0,0,0); chk("ab_nsg", 3'd1, G, R, 1'b0);

    // reset during PED_WALK cnt=3 with EW demand pending and ped_req on the reset edge
    cyc(0,0,0,1,0); chk("rm_nsg1", 3'd1, G, R, 1'b0);
    for (int i = 0; i < 2; i++) begin cyc(0,0,0,0,0); chk("rm_nsg", 3'd1, G, R, 1'b0); end
    for (int i = 0; i < 3; i++) begin cyc(0,0,0,0,0); chk("rm_nsy", 3'd2, Y, R, 1'b0); end
    for (int i = 0; i < 2; i++) begin cyc(0,0,0,0,0); chk("rm_ar", 3'd0, R, R, 1'b0); end
    cyc(0,0,0,0,0); chk("rm_walk0", 3'd5, R, R, 1'b1);
    cyc(0,0,1,0,0); chk("rm_walk1", 3'd5, R, R, 1'b1);
    cyc(0,0,0,0,0); chk("rm_walk2", 3'd5, R, R, 1'b1);
    cyc(0,0,0,0,0); chk("rm_walk3", 3'd5, R, R, 1'b1);
    cyc(1,0,0,1,0); chk("rm_reset", 3'd0, R, R, 1'b0);
    cyc(0,0,0,0,0); chk("rm_ar1", 3'd0, R, R, 1'b0);
    cyc(0,0,0,0,0); chk("rm_first_ns", 3'd1, G, R, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(0,0,0,0,0); chk($sformatf("rm_rest%0d", i), 3'd1, G, R, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
